nios_pio_in_debounced_irq: RTL and testbench

//  Parametrised Avalon-MM input PIO for Nios II systems (buttons, switches).
//  Per-channel 2-flop synchroniser, per-channel debounce filter, edge-capture

---
 rtl/nios_pio_in_debounced_irq.sv | 129 ++++++++++++
 tb/tb_nios_pio_in_debounced_irq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_pio_in_debounced_irq.sv
// Avalon-MM input PIO: per-channel 2-flop synchroniser, debounce filter, edge capture
// with configurable edge sense, and a maskable level interrupt. Read latency is 1.
module nios_pio_in_debounced_irq #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] AddrData = 2'd0;
    localparam logic [1:0] AddrRsvd = 2'd1;
    localparam logic [1:0] AddrMask = 2'd2;
    localparam logic [1:0] AddrEdge = 2'd3;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH must be in 1..32");
    end
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be in 1..65535");
    end
    if (EDGE_MODE > 2) begin : g_bad_edge_mode
        $error("EDGE_MODE must be 0, 1 or 2");
    end

    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] prev_q;
    logic [CntW-1:0]  cnt_q [WIDTH];
    logic [CntW-1:0]  cnt_d [WIDTH];
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] rise, fall, ev, clr;
    logic [31:0]      readdata_d;
    logic             irq_d;
    logic             wr_en;

    // Each channel counts consecutive disagreements with its accepted level; any
    // agreement restarts the count, so only a run of DEBOUNCE_CYCLES samples flips it.
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    stable_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign rise = stable_q & ~prev_q;
    assign fall = ~stable_q & prev_q;

    if (EDGE_MODE == 0) begin : g_ev_rise
        assign ev = rise;
    end else if (EDGE_MODE == 1) begin : g_ev_fall
        assign ev = fall;
    end else begin : g_ev_any
        assign ev = rise | fall;
    end

    assign wr_en = chipselect & write;

    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && address == AddrMask) begin
            mask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == AddrEdge) begin
            clr = writedata[WIDTH-1:0];
        end
        // A new event outranks a same-cycle clear of that bit.
        edge_d = (edge_q & ~clr) | ev;
    end

    // Reads see the pre-write register contents; chipselect does not gate reads.
    always_comb begin
        readdata_d = '0;
        case (address)
            AddrData: readdata_d[WIDTH-1:0] = stable_q;
            AddrRsvd: readdata_d            = '0;
            AddrMask: readdata_d[WIDTH-1:0] = mask_q;
            AddrEdge: readdata_d[WIDTH-1:0] = edge_q;
            default:  readdata_d            = '0;
        endcase
    end

    assign irq_d = |(edge_q & mask_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            cnt_q    <= '{default: '0};
            mask_q   <= '0;
            edge_q   <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            s1_q     <= in_port;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            edge_q   <= edge_d;
            readdata <= readdata_d;
            irq      <= irq_d;
        end
    end

endmodule

// File: tb/tb_nios_pio_in_debounced_irq.sv
// Bench for nios_pio_in_debounced_irq: three instances (rising/falling/any edge) share
// stimulus and are checked every cycle against a sliding-window model, plus literal checks.
module tb_nios_pio_in_debounced_irq;

    localparam int W  = 4;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [3:0]  in_port = '0;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nios_pio_in_debounced_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd0), .in_port(in_port), .irq(irq0));
    nios_pio_in_debounced_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd1), .in_port(in_port), .irq(irq1));
    nios_pio_in_debounced_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_MODE(2)) dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write(write),
        .writedata(writedata), .readdata(rd2), .in_port(in_port), .irq(irq2));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: accepted level flips once the last DC synchronised samples all disagree.
    bit [3:0]  m_s1, m_s2, m_stable, m_prev, m_mask;
    bit [3:0]  m_ec [3];
    bit        m_irq [3];
    bit [31:0] m_rd [3];
    bit [3:0]  hist [$];
    bit        m_valid = 1'b0;

    function automatic bit [3:0] ev_of(input int mode, input bit [3:0] cur, input bit [3:0] old);
        if (mode == 0) return cur & ~old;
        if (mode == 1) return ~cur & old;
        return cur ^ old;
    endfunction

    task automatic model_step(input bit rst, input bit [1:0] a, input bit we,
                              input bit [31:0] wd, input bit [3:0] pin);
        bit [3:0] nstable;
        bit [3:0] clr;
        bit       all_diff;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_mask = '0;
            for (int m = 0; m < 3; m++) begin
                m_ec[m] = '0; m_irq[m] = 1'b0; m_rd[m] = '0;
            end
            hist.delete();
            m_valid = 1'b1;
            return;
        end
        nstable = m_stable;
        hist.push_back(m_s2);
        if (hist.size() > DC) void'(hist.pop_front());
        if (hist.size() == DC) begin
            for (int i = 0; i < W; i++) begin
                all_diff = 1'b1;
                foreach (hist[k]) if (hist[k][i] == m_stable[i]) all_diff = 1'b0;
                if (all_diff) nstable[i] = ~m_stable[i];
            end
        end
        clr = (we && a == 2'd3) ? wd[3:0] : 4'd0;
        for (int m = 0; m < 3; m++) begin
            case (a)
                2'd0:    m_rd[m] = {28'd0, m_stable};
                2'd2:    m_rd[m] = {28'd0, m_mask};
                2'd3:    m_rd[m] = {28'd0, m_ec[m]};
                default: m_rd[m] = '0;
            endcase
            m_irq[m] = |(m_ec[m] & m_mask);
            m_ec[m]  = (m_ec[m] & ~clr) | ev_of(m, m_stable, m_prev);
        end
        if (we && a == 2'd2) m_mask = wd[3:0];
        m_prev   = m_stable;
        m_stable = nstable;
        m_s2     = m_s1;
        m_s1     = pin;
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after each rising edge.
    initial begin
        bit        s_rst, s_we;
        bit [1:0]  s_a;
        bit [31:0] s_wd;
        bit [3:0]  s_pin;
        forever begin
            @(posedge clk);
            s_rst = reset; s_a = address; s_we = chipselect & write;
            s_wd = writedata; s_pin = in_port;
            #1;
            model_step(s_rst, s_a, s_we, s_wd, s_pin);
            if (m_valid) begin
                chk("model readdata dut0", rd0, m_rd[0]);
                chk("model readdata dut1", rd1, m_rd[1]);
                chk("model readdata dut2", rd2, m_rd[2]);
                chk("model irq dut0", {31'd0, irq0}, {31'd0, m_irq[0]});
                chk("model irq dut1", {31'd0, irq1}, {31'd0, m_irq[1]});
                chk("model irq dut2", {31'd0, irq2}, {31'd0, m_irq[2]});
            end
        end
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, input logic [3:0] e0, input logic [3:0] e1,
                      input logic [3:0] e2, input string n);
        address = a;
        @(negedge clk);
        chk({n, " dut0"}, rd0, {28'd0, e0});
        chk({n, " dut1"}, rd1, {28'd0, e1});
        chk({n, " dut2"}, rd2, {28'd0, e2});
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    initial begin
        // Reset
        wait_n(3);
        chk("reset readdata", rd0, 32'd0);
        chk("reset irq", {31'd0, irq0}, 32'd0);
        reset = 1'b0;
        rd(2'd2, 4'h0, 4'h0, 4'h0, "reset irqmask");
        rd(2'd3, 4'h0, 4'h0, 4'h0, "reset edgecapture");

        // Clean step: stable updates on edge 6, readdata shows it one edge later
        address = 2'd0;
        in_port = 4'b0001;
        wait_n(6);
        chk("step data not early", rd0, 32'd0);
        wait_n(1);
        chk("step data on time", rd0, 32'd1);
        wait_n(2);
        rd(2'd3, 4'h1, 4'h0, 4'h1, "step edgecapture");
        chk("step irq masked", {31'd0, irq0}, 32'd0);
        in_port = 4'b0000;
        wait_n(10);
        wr(2'd3, 32'hF);
        wait_n(2);

        // Bounce shorter than the filter window never gets through
        address = 2'd0;
        for (int k = 0; k < 20; k++) begin
            in_port = ((k >> 1) & 1) != 0 ? 4'b0001 : 4'b0000;
            @(negedge clk);
            chk("bounce data", rd0, 32'd0);
            chk("bounce irq", {31'd0, irq0}, 32'd0);
        end
        in_port = 4'b0000;
        wait_n(8);
        rd(2'd3, 4'h0, 4'h0, 4'h0, "bounce edgecapture");

        // Interrupt assert / W1C deassert timing
        wr(2'd2, 32'hF);
        in_port = 4'b0100;
        wait_n(7);
        chk("irq not before capture", {31'd0, irq0}, 32'd0);
        wait_n(1);
        chk("irq asserted dut0", {31'd0, irq0}, 32'd1);
        chk("irq fall-mode quiet", {31'd0, irq1}, 32'd0);
        chk("irq asserted dut2", {31'd0, irq2}, 32'd1);
        rd(2'd3, 4'h4, 4'h0, 4'h4, "irq edgecapture");
        wr(2'd3, 32'h4);
        chk("irq held through clear edge", {31'd0, irq0}, 32'd1);
        wait_n(1);
        chk("irq deasserted", {31'd0, irq0}, 32'd0);
        rd(2'd3, 4'h0, 4'h0, 4'h0, "cleared edgecapture");
        in_port = 4'b0000;
        wait_n(10);
        wr(2'd3, 32'hF);
        wait_n(2);

        // Collision: clear of bit1 on the very edge a new bit1 event is captured
        in_port = 4'b0010;
        wait_n(10);
        in_port = 4'b0000;
        wait_n(10);
        in_port = 4'b0010;
        wait_n(6);
        address = 2'd3; writedata = 32'h2; chipselect = 1'b1; write = 1'b1;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
        chk("collision irq edge", {31'd0, irq0}, 32'd1);
        wait_n(1);
        chk("collision irq after", {31'd0, irq0}, 32'd1);
        rd(2'd3, 4'h2, 4'h0, 4'h2, "collision edgecapture");

        // Edge sense on bit3
        in_port = 4'b0000;
        wait_n(10);
        wr(2'd3, 32'hF);
        wait_n(2);
        in_port = 4'b1000;
        wait_n(10);
        rd(2'd3, 4'h8, 4'h0, 4'h8, "bit3 rise edgecapture");
        in_port = 4'b0000;
        wait_n(10);
        rd(2'd3, 4'h8, 4'h8, 4'h8, "bit3 fall edgecapture");

        // Randomised traffic, including occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < W; i++) begin
                if ($urandom_range(0, 7) == 0) in_port[i] = ~in_port[i];
            end
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write      = ($urandom_range(0, 5) == 0);
            writedata  = $urandom;
        end
        @(negedge clk);
        reset = 1'b0; chipselect = 1'b0; write = 1'b0;
        wait_n(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
